uart_rx_periph: RTL and testbench

//   Memory-mapped UART receiver at address 32'h70. It is the responder side of the

---
 rtl/uart_rx_periph_pkg.sv | 21 ++
 rtl/uart_rx_fifo.sv | 58 +++++
 rtl/uart_rx_periph.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_periph.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_periph_pkg.sv
// Shared definitions for the UART receive peripheral: bus addresses, RX FSM
// state encoding and the read-data formatting helper.
package uart_rx_periph_pkg;

  typedef enum logic [31:0] {
    UART_ADDR = 32'h0000_0070,
    LEDS_ADDR = 32'h0000_0078
  } io_addr_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  function automatic logic [31:0] zext_byte(input logic [7:0] b);
    return {24'h0, b};
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// DEPTH x 8 receive FIFO with a combinational head output. A push on a full
// FIFO is accepted only when a pop in the same cycle frees a slot.
module uart_rx_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok;
  logic          push_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; entries are only visible once counted in.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/uart_rx_periph.sv
// Memory-mapped 8N1 UART receiver: rx synchroniser, mid-bit sampling FSM,
// receive FIFO, sticky error flags and the byte-available interrupt pulse.
module uart_rx_periph
  import uart_rx_periph_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        load_uart,
  input  logic        uart_read_end,
  input  logic        err_clr,
  output logic [31:0] rd_data,
  output logic        int_sig,
  output logic        rx_empty,
  output logic        frame_err,
  output logic        overrun
);

  localparam int BW = $clog2(CLK_DIV);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] HALF_LOAD = BW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0] FULL_LOAD = BW'(CLK_DIV - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  rx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          int_q, int_d;
  logic          pend_q, pend_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;

  logic          push_req;
  logic          ferr_set;
  logic          pop_ok;
  logic          push_acc;
  logic          int_event;
  logic [7:0]    fifo_dout;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;

  // rd_data is always driven from the head; load_uart only tells the CPU when to latch it.
  logic unused_load_uart;
  assign unused_load_uart = load_uart;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (uart_read_end),
    .din   (shift_q),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_comb begin
    sync1_d   = rx;
    sync2_d   = sync1_q;
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    ferr_set  = 1'b0;

    case (state_q)
      RX_IDLE: begin
        if (!sync2_q) begin
          state_d = RX_START;
          baud_d  = HALF_LOAD;
        end
      end
      RX_START: begin
        if (baud_q == '0) begin
          if (sync2_q) begin
            state_d = RX_IDLE;
          end else begin
            state_d   = RX_DATA;
            bit_idx_d = 3'd0;
            baud_d    = FULL_LOAD;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      RX_DATA: begin
        if (baud_q == '0) begin
          shift_d = {sync2_q, shift_q[7:1]};
          baud_d  = FULL_LOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      RX_STOP: begin
        if (baud_q == '0) begin
          state_d  = RX_IDLE;
          push_req = sync2_q;
          ferr_set = !sync2_q;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase

    // A full FIFO only takes the byte if a pop in the same cycle frees a slot.
    pop_ok    = uart_read_end && !fifo_empty;
    push_acc  = push_req && (!fifo_full || pop_ok);
    int_event = push_acc || (pop_ok && (fifo_count > CW'(1)));

    // Keep at least one low cycle between pulses; a blocked event is deferred, not lost.
    int_d  = !int_q && (int_event || pend_q);
    pend_d = (pend_q || int_event) && !int_d;

    frame_err_d = ferr_set ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);
    overrun_d   = (push_req && !push_acc) ? 1'b1 : (err_clr ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= RX_IDLE;
      baud_q      <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      int_q       <= 1'b0;
      pend_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      int_q       <= int_d;
      pend_q      <= pend_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rd_data   = fifo_empty ? 32'h0 : zext_byte(fifo_dout);
  assign int_sig   = int_q;
  assign rx_empty  = fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_periph.sv
// Bench for uart_rx_periph: directed frames plus randomized traffic, checked
// every cycle against a queue-based model of the receiver's visible behaviour.
module tb_uart_rx_periph;

  localparam int CLK_DIV = 16;
  localparam int DEPTH   = 4;
  // Frame start to byte visible: 2 sync stages, half a bit, 9 full bits, 1 register.
  localparam int PUSH_LAT = 2 + CLK_DIV / 2 + 9 * CLK_DIV + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        load_uart = 1'b0;
  logic        uart_read_end = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] rd_data;
  logic        int_sig;
  logic        rx_empty;
  logic        frame_err;
  logic        overrun;

  uart_rx_periph #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .load_uart     (load_uart),
    .uart_read_end (uart_read_end),
    .err_clr       (err_clr),
    .rd_data       (rd_data),
    .int_sig       (int_sig),
    .rx_empty      (rx_empty),
    .frame_err     (frame_err),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state
  int         cyc = 0;
  logic [7:0] mq[$];
  bit         m_int = 0, m_pend = 0, m_ferr = 0, m_ovr = 0;
  int         sched_c = -1;
  logic [7:0] sched_byte = 8'h00;
  bit         sched_good = 1'b1;
  int         sched_id = 0;
  int         used_id = 0;

  // Observation state
  bit cmp_en = 0;
  bit int_prev = 0;
  int int_rises = 0;
  int int_hi = 0;
  int last_rise = -1;
  int frame_start = 0;
  bit rand_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: byte arrives PUSH_LAT edges after its frame started.
  initial begin
    bit push_now, bad_now, pop_ok, push_ok, ev, int_new;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (rst) begin
        mq.delete();
        m_int = 0; m_pend = 0; m_ferr = 0; m_ovr = 0;
        used_id = sched_id;
      end else begin
        push_now = 0;
        bad_now  = 0;
        if (sched_id != used_id && cyc == sched_c) begin
          used_id = sched_id;
          if (sched_good) push_now = 1; else bad_now = 1;
        end
        pop_ok  = uart_read_end && (mq.size() > 0);
        push_ok = push_now && ((mq.size() < DEPTH) || pop_ok);
        if (pop_ok) void'(mq.pop_front());
        if (push_ok) mq.push_back(sched_byte);
        ev = push_ok || (pop_ok && (mq.size() > 0));
        int_new = !m_int && (ev || m_pend);
        m_pend  = (m_pend || ev) && !int_new;
        m_int   = int_new;
        if (bad_now) m_ferr = 1; else if (err_clr) m_ferr = 0;
        if (push_now && !push_ok) m_ovr = 1; else if (err_clr) m_ovr = 0;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    logic [31:0] exp_rd;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        exp_rd = (mq.size() > 0) ? {24'h0, mq[0]} : 32'h0;
        chk("rd_data", rd_data, exp_rd);
        chk("rx_empty", {31'h0, rx_empty}, {31'h0, mq.size() == 0});
        chk("int_sig", {31'h0, int_sig}, {31'h0, m_int});
        chk("frame_err", {31'h0, frame_err}, {31'h0, m_ferr});
        chk("overrun", {31'h0, overrun}, {31'h0, m_ovr});
        if (int_sig && !int_prev) begin
          int_rises++;
          last_rise = cyc;
        end
        if (int_sig) int_hi++;
        int_prev = int_sig;
      end
    end
  end

  // Drive one 8N1 frame; optionally pop in the stop-sample cycle or reset mid-frame.
  task automatic send_frame(input logic [7:0] b, input bit good_stop, input int rst_at,
                            input bit pop_at_stop);
    logic [9:0] bits;
    bit aborted;
    bits    = {good_stop, b, 1'b0};
    aborted = 0;
    frame_start = cyc;
    sched_c    = cyc + PUSH_LAT;
    sched_byte = b;
    sched_good = good_stop;
    sched_id++;
    for (int k = 0; k < 10 * CLK_DIV && !aborted; k++) begin
      rx = bits[k / CLK_DIV];
      if (pop_at_stop) begin
        uart_read_end = (k == PUSH_LAT - 1);
        load_uart     = uart_read_end;
      end
      if (k == rst_at) begin
        rst = 1'b1;
        rx  = 1'b1;
      end
      step(1);
      if (rst) begin
        rst = 1'b0;
        aborted = 1;
      end
    end
    rx = 1'b1;
    if (!aborted) step(CLK_DIV);
  endtask

  task automatic do_pop();
    load_uart     = 1'b1;
    uart_read_end = 1'b1;
    step(1);
    load_uart     = 1'b0;
    uart_read_end = 1'b0;
  endtask

  initial begin
    int r0, h0;
    logic [7:0] t5_exp [4];
    t5_exp = '{8'h22, 8'h33, 8'h44, 8'h55};

    // Reset state
    rst = 1'b1;
    step(3);
    cmp_en = 1;
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_rx_empty", {31'h0, rx_empty}, 32'h1);
    chk("reset_int", {31'h0, int_sig}, 32'h0);
    chk("reset_flags", {30'h0, frame_err, overrun}, 32'h0);
    rst = 1'b0;
    step(2);

    // 1: single frame, latency and pulse width
    r0 = int_rises; h0 = int_hi;
    send_frame(8'hA5, 1, -1, 0);
    chk("t1_rd_data", rd_data, 32'h0000_00A5);
    chk("t1_rx_empty", {31'h0, rx_empty}, 32'h0);
    chk("t1_int_latency", last_rise, frame_start + PUSH_LAT);
    chk("t1_int_pulses", int_rises - r0, 1);
    chk("t1_int_width", int_hi - h0, 1);
    do_pop();
    step(2);

    // 2: false start, then a clean frame
    r0 = int_rises;
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    step(40);
    chk("t2_no_int", int_rises - r0, 0);
    chk("t2_rx_empty", {31'h0, rx_empty}, 32'h1);
    send_frame(8'h96, 1, -1, 0);
    chk("t2_rd_data", rd_data, 32'h0000_0096);
    do_pop();
    step(2);

    // 3: framing error and clear
    send_frame(8'h3C, 0, -1, 0);
    chk("t3_frame_err", {31'h0, frame_err}, 32'h1);
    chk("t3_rx_empty", {31'h0, rx_empty}, 32'h1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("t3_frame_err_clr", {31'h0, frame_err}, 32'h0);

    // 4: overrun on the fifth byte, ordered pops with re-raise
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1, -1, 0);
    chk("t4_overrun", {31'h0, overrun}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      r0 = int_rises;
      chk("t4_pop_data", rd_data, 32'(i + 1));
      do_pop();
      step(3);
      chk("t4_repulse", int_rises - r0, (i < 3) ? 1 : 0);
    end
    chk("t4_rx_empty", {31'h0, rx_empty}, 32'h1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("t4_overrun_clr", {31'h0, overrun}, 32'h0);

    // 5: push and pop in the same cycle on a full FIFO
    send_frame(8'h11, 1, -1, 0);
    send_frame(8'h22, 1, -1, 0);
    send_frame(8'h33, 1, -1, 0);
    send_frame(8'h44, 1, -1, 0);
    send_frame(8'h55, 1, -1, 1);
    chk("t5_overrun", {31'h0, overrun}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("t5_pop_data", rd_data, {24'h0, t5_exp[i]});
      do_pop();
      step(2);
    end
    chk("t5_rx_empty", {31'h0, rx_empty}, 32'h1);

    // 6: reset during data bit 4
    send_frame(8'h77, 1, -1, 0);
    send_frame(8'h12, 1, 5 * CLK_DIV + 4, 0);
    chk("t6_rx_empty", {31'h0, rx_empty}, 32'h1);
    chk("t6_rd_data", rd_data, 32'h0);
    step(5);
    send_frame(8'h5A, 1, -1, 0);
    chk("t6_rd_data_5a", rd_data, 32'h0000_005A);
    do_pop();
    step(2);

    // Randomized traffic with concurrent pops and error clears
    fork
      begin
        for (int f = 0; f < 25; f++) begin
          send_frame(8'($urandom), ($urandom_range(0, 9) != 0), -1, 0);
          step($urandom_range(4, 40));
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          uart_read_end = ($urandom_range(0, 15) == 0);
          load_uart     = uart_read_end;
          err_clr       = ($urandom_range(0, 63) == 0);
          step(1);
        end
        uart_read_end = 1'b0;
        load_uart     = 1'b0;
        err_clr       = 1'b0;
      end
    join
    for (int i = 0; i < DEPTH; i++) begin
      do_pop();
      step(2);
    end
    chk("final_rx_empty", {31'h0, rx_empty}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
